// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and helpers for the SPI slave block.
//   SPI_MODE0..3      : {CPOL, CPHA} encodings
//   SYNC_RST_CS_N/MOSI: reset values for the bus synchronisers
//   spi_cfg_t         : per-frame latched configuration
//   clog2()           : ceiling log2 for sizing pointers/counters
package spi_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam logic SYNC_RST_CS_N = 1'b1;
  localparam logic SYNC_RST_MOSI = 1'b0;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_cfg_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/spi_slave_fifo_if.sv
// spi_slave_fifo_if: SPI bus plus TX push / RX pop handshakes.
//   sclk, cs_n, mosi : from the external master (asynchronous)
//   miso, miso_oe    : serial out and its pad enable
//   tx_data/valid/ready : push port into the TX FIFO
//   rx_data/valid/ready : pop port from the RX FIFO head
// Modport slave is the SPI block; master is the surrounding logic/bus.
interface spi_slave_fifo_if #(parameter int DATA_WIDTH = 8);
  logic                  sclk;
  logic                  cs_n;
  logic                  mosi;
  logic                  miso;
  logic                  miso_oe;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;

  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_valid, rx_ready,
    output miso, miso_oe, tx_ready, rx_data, rx_valid
  );

  modport master (
    output sclk, cs_n, mosi, tx_data, tx_valid, rx_ready,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, first-word-fall-through head.
//   in_data/in_valid/in_ready    : push side, in_ready = !full
//   out_data/out_valid/out_ready : pop side, out_valid = !empty
// Pointers carry one extra wrap bit to tell full from empty. The head
// reads as zero while empty so the output is defined out of reset.
module sync_fifo
  import spi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             empty, full, push, pop;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & ~full;
  assign pop       = out_ready & ~empty;
  assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

endmodule

// File: rtl/spi_slave_fifo.sv
// spi_slave_fifo: SPI slave with runtime CPOL/CPHA/bit order, TX and RX FIFOs.
//   clk, rst_n        : system clock, synchronous active-low reset
//   cfg_cpol/cpha/lsb_first : mode, latched when a frame starts
//   bus (slave)       : SPI pins plus TX push / RX pop handshakes
//   tx_underrun       : pulse, a word load found the TX FIFO empty
//   rx_overrun        : pulse, a finished RX word was dropped (FIFO full)
//   busy              : synchronised cs_n is low
// All SPI pins pass through SYNC_STAGES flops plus one history flop; edges
// are taken between the last stage and the history flop.
module spi_slave_fifo
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int TX_DEPTH    = 4,
  parameter int RX_DEPTH    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_cpol,
  input  logic                 cfg_cpha,
  input  logic                 cfg_lsb_first,
  spi_slave_fifo_if.slave      bus,
  output logic                 tx_underrun,
  output logic                 rx_overrun,
  output logic                 busy
);
  localparam int CW = clog2(DATA_WIDTH);
  localparam int S  = SYNC_STAGES;

  logic [S-1:0] sclk_sync, cs_sync, mosi_sync;
  logic         sclk_hist, cs_hist;
  logic         sclk_s, cs_s, mosi_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync <= {S{cfg_cpol}};
      cs_sync   <= {S{SYNC_RST_CS_N}};
      mosi_sync <= {S{SYNC_RST_MOSI}};
      sclk_hist <= cfg_cpol;
      cs_hist   <= SYNC_RST_CS_N;
    end else begin
      sclk_sync <= {sclk_sync[S-2:0], bus.sclk};
      cs_sync   <= {cs_sync[S-2:0],   bus.cs_n};
      mosi_sync <= {mosi_sync[S-2:0], bus.mosi};
      sclk_hist <= sclk_sync[S-1];
      cs_hist   <= cs_sync[S-1];
    end
  end

  assign sclk_s = sclk_sync[S-1];
  assign cs_s   = cs_sync[S-1];
  assign mosi_s = mosi_sync[S-1];

  spi_cfg_t              cfg_q;
  logic                  load_pending;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] tx_sr, rx_sr, rx_next, tx_head, load_word;
  logic                  tx_head_valid, rx_in_ready;
  logic                  frame_start, frame_end, in_frame;
  logic                  sclk_edge, lead, trail, shift_edge, sample_edge;
  logic                  word_done, do_load;

  assign frame_start = cs_hist & ~cs_s;
  assign frame_end   = ~cs_hist & cs_s;
  // Only edges strictly inside a frame count; a frame-end cycle therefore
  // drops any sample edge that coincides with it.
  assign in_frame    = ~cs_hist & ~cs_s;

  assign sclk_edge   = sclk_s ^ sclk_hist;
  assign lead        = in_frame & sclk_edge & (sclk_s != cfg_q.cpol);
  assign trail       = in_frame & sclk_edge & (sclk_s == cfg_q.cpol);
  assign shift_edge  = cfg_q.cpha ? lead  : trail;
  assign sample_edge = cfg_q.cpha ? trail : lead;
  assign word_done   = sample_edge & (cnt == CW'(DATA_WIDTH-1));

  // CPHA=0 must present bit 0 before the first edge, so it loads at frame
  // start using the live cfg input (the latch happens on the same edge).
  assign do_load   = (frame_start & ~cfg_cpha) | (shift_edge & load_pending);
  assign load_word = tx_head_valid ? tx_head : '0;

  assign rx_next = cfg_q.lsb_first ? {mosi_s, rx_sr[DATA_WIDTH-1:1]}
                                   : {rx_sr[DATA_WIDTH-2:0], mosi_s};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_q        <= '{cpol: cfg_cpol, cpha: 1'b0, lsb_first: 1'b0};
      load_pending <= 1'b0;
      cnt          <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      tx_underrun  <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      tx_underrun <= do_load & ~tx_head_valid;
      rx_overrun  <= word_done & ~rx_in_ready;
      if (frame_start) begin
        cfg_q        <= '{cpol: cfg_cpol, cpha: cfg_cpha, lsb_first: cfg_lsb_first};
        cnt          <= '0;
        load_pending <= cfg_cpha;
        rx_sr        <= '0;
        tx_sr        <= cfg_cpha ? '0 : load_word;
      end else if (frame_end) begin
        cnt          <= '0;
        load_pending <= 1'b0;
        tx_sr        <= '0;
      end else begin
        if (shift_edge) begin
          if (load_pending) begin
            tx_sr        <= load_word;
            load_pending <= 1'b0;
          end else begin
            tx_sr <= cfg_q.lsb_first ? (tx_sr >> 1) : (tx_sr << 1);
          end
        end
        if (sample_edge) begin
          rx_sr <= rx_next;
          if (word_done) begin
            cnt          <= '0;
            load_pending <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      end
    end
  end

  assign busy        = ~cs_s;
  assign bus.miso_oe = ~cs_s;
  assign bus.miso    = ~cs_s & (cfg_q.lsb_first ? tx_sr[0] : tx_sr[DATA_WIDTH-1]);

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (bus.tx_data),
    .in_valid (bus.tx_valid),
    .in_ready (bus.tx_ready),
    .out_data (tx_head),
    .out_valid(tx_head_valid),
    .out_ready(do_load)
  );

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (rx_next),
    .in_valid (word_done),
    .in_ready (rx_in_ready),
    .out_data (bus.rx_data),
    .out_valid(bus.rx_valid),
    .out_ready(bus.rx_ready)
  );

endmodule

// File: tb/tb_spi_slave_fifo.sv
// tb_spi_slave_fifo: drives the slave as an SPI master, checks serial data,
// FIFO contents and flag pulses against a word-level model of the bus.
module tb_spi_slave_fifo;
  import spi_pkg::*;

  localparam int DW  = 8;
  localparam int TXD = 4;
  localparam int RXD = 4;
  localparam int SS  = 2;
  localparam int H   = 10;  // sclk half-period in clk cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb_first = 1'b0;
  logic tx_underrun, rx_overrun, busy;

  spi_slave_fifo_if #(.DATA_WIDTH(DW)) bus ();

  always #5 clk = ~clk;

  spi_slave_fifo #(.DATA_WIDTH(DW), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .SYNC_STAGES(SS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_cpol     (cfg_cpol),
    .cfg_cpha     (cfg_cpha),
    .cfg_lsb_first(cfg_lsb_first),
    .bus          (bus),
    .tx_underrun  (tx_underrun),
    .rx_overrun   (rx_overrun),
    .busy         (busy)
  );

  int vectors = 0;
  int errors  = 0;
  int und_total = 0;
  int ovr_total = 0;

  logic [DW-1:0] tx_q[$];
  logic [DW-1:0] rx_q[$];
  logic [DW-1:0] mosi_q[$];

  always @(negedge clk) begin
    if (tx_underrun === 1'b1) und_total++;
    if (rx_overrun === 1'b1)  ovr_total++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input logic [DW-1:0] w);
    chk("tx_ready", bus.tx_ready, 1);
    bus.tx_data  = w;
    bus.tx_valid = 1'b1;
    cyc(1);
    bus.tx_valid = 1'b0;
    tx_q.push_back(w);
  endtask

  // One chip-select frame of nbits with mosi_q as the master's words.
  // Model: CPHA=0 loads once at start plus once after every finished word
  // (the closing trailing edge); CPHA=1 loads once per word begun.
  task automatic frame(input logic [1:0] mode, input logic lsb, input int nbits);
    logic cpol, cpha, mbit, ebit;
    int loads, und, ovr, u0, o0, wi, bi;
    logic [DW-1:0] exp_tx[$];
    cpol = mode[1];
    cpha = mode[0];
    loads = cpha ? (nbits + DW - 1) / DW : 1 + nbits / DW;
    und = 0;
    ovr = 0;
    for (int k = 0; k < loads; k++) begin
      if (tx_q.size() > 0) exp_tx.push_back(tx_q.pop_front());
      else begin
        exp_tx.push_back('0);
        und++;
      end
    end
    for (int w = 0; w < nbits / DW; w++) begin
      if (rx_q.size() < RXD) rx_q.push_back(mosi_q[w]);
      else ovr++;
    end
    u0 = und_total;
    o0 = ovr_total;
    cfg_cpol = cpol;
    cfg_cpha = cpha;
    cfg_lsb_first = lsb;
    bus.sclk = cpol;
    cyc(2*H);
    bus.cs_n = 1'b0;
    cyc(H/2);
    for (int b = 0; b < nbits; b++) begin
      wi = b / DW;
      bi = lsb ? (b % DW) : (DW - 1 - (b % DW));
      mbit = mosi_q[wi][bi];
      ebit = exp_tx[wi][bi];
      if (!cpha) begin
        cyc(H/2);
        bus.mosi = mbit;
        cyc(H/2);
        chk("miso_bit", bus.miso, ebit);
        bus.sclk = ~cpol;
        cyc(H);
        bus.sclk = cpol;
      end else begin
        bus.sclk = ~cpol;
        cyc(H/2);
        bus.mosi = mbit;
        cyc(H/2);
        chk("miso_bit", bus.miso, ebit);
        bus.sclk = cpol;
        cyc(H);
      end
      if (b == 0) begin
        chk("busy", busy, 1);
        chk("miso_oe", bus.miso_oe, 1);
      end
    end
    cyc(H);
    bus.cs_n = 1'b1;
    cyc(2*H);
    chk("tx_underrun_cnt", und_total - u0, und);
    chk("rx_overrun_cnt", ovr_total - o0, ovr);
    chk("miso_idle", bus.miso, 0);
    chk("busy_idle", busy, 0);
  endtask

  task automatic drain();
    while (rx_q.size() > 0) begin
      chk("rx_valid", bus.rx_valid, 1);
      chk("rx_data", bus.rx_data, rx_q.pop_front());
      bus.rx_ready = 1'b1;
      cyc(1);
      bus.rx_ready = 1'b0;
    end
    chk("rx_empty", bus.rx_valid, 0);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_miso"}, bus.miso, 0);
    chk({tag, "_miso_oe"}, bus.miso_oe, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tx_ready"}, bus.tx_ready, 1);
    chk({tag, "_rx_valid"}, bus.rx_valid, 0);
    chk({tag, "_rx_data"}, bus.rx_data, 0);
    chk({tag, "_tx_underrun"}, tx_underrun, 0);
    chk({tag, "_rx_overrun"}, rx_overrun, 0);
  endtask

  initial begin
    int nw, nbits;
    logic [1:0] mode;
    logic lsb;
    bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0;
    bus.tx_data = '0; bus.tx_valid = 1'b0; bus.rx_ready = 1'b0;
    cyc(5);
    reset_vals("rst");
    rst_n = 1'b1;
    cyc(5);
    reset_vals("post_rst");

    // Mode 0 MSB-first: 0xA5 out, 0x3C in
    push_tx(8'hA5);
    mosi_q = '{8'h3C};
    frame(SPI_MODE0, 1'b0, DW);
    drain();

    // Modes 1..3 LSB-first: 0x81 out, 0x01 in
    for (int m = 1; m < 4; m++) begin
      push_tx(8'h81);
      mosi_q = '{8'h01};
      frame(2'(m), 1'b1, DW);
      drain();
    end

    // Back-to-back words in one frame
    push_tx(8'h11); push_tx(8'h22); push_tx(8'h33);
    mosi_q = '{8'hAA, 8'hBB, 8'hCC};
    frame(SPI_MODE0, 1'b0, 3*DW);
    drain();
    chk("tx_q_empty", tx_q.size(), 0);

    // Nothing queued for transmit
    mosi_q = '{8'h5A};
    frame(SPI_MODE3, 1'b0, DW);
    drain();

    // RX overrun: one word more than the RX FIFO holds
    for (int i = 0; i < TXD; i++) push_tx(8'(8'hC0 + i));
    mosi_q = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54};
    frame(SPI_MODE1, 1'b0, (RXD+1)*DW);
    drain();

    // Aborted after 5 bits, then a clean frame
    push_tx(8'h6E);
    mosi_q = '{8'hF0};
    frame(SPI_MODE0, 1'b0, 5);
    drain();
    push_tx(8'h9D);
    mosi_q = '{8'h47};
    frame(SPI_MODE2, 1'b1, DW);
    drain();

    // Reset in the middle of a frame, cs_n held low across release
    for (int i = 0; i < TXD; i++) push_tx(8'(i + 1));
    chk("tx_full", bus.tx_ready, 0);
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0;
    bus.sclk = 1'b0;
    cyc(2*H);
    bus.cs_n = 1'b0;
    for (int b = 0; b < 3; b++) begin
      cyc(H); bus.sclk = 1'b1; cyc(H); bus.sclk = 1'b0;
    end
    cyc(H/2);
    rst_n = 1'b0;
    cyc(3);
    reset_vals("mid_rst");
    rst_n = 1'b1;
    tx_q.delete();
    rx_q.delete();
    cyc(SS + 4);
    chk("restart_busy", busy, 1);
    bus.cs_n = 1'b1;
    cyc(2*H);
    chk("after_rst_rx_valid", bus.rx_valid, 0);
    chk("after_rst_tx_ready", bus.tx_ready, 1);

    // Randomised frames
    for (int t = 0; t < 25; t++) begin
      mode = 2'($urandom_range(0, 3));
      lsb  = 1'($urandom_range(0, 1));
      nw   = $urandom_range(1, 3);
      nbits = nw * DW;
      if ($urandom_range(0, 4) == 0) nbits = nbits - $urandom_range(1, DW-1);
      for (int i = $urandom_range(0, 3); i > 0 && tx_q.size() < TXD; i--)
        push_tx(8'($urandom));
      mosi_q.delete();
      for (int i = 0; i < nw; i++) mosi_q.push_back(8'($urandom));
      frame(mode, lsb, nbits);
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
